// File: rtl/tbird_sequencer_pkg.sv
// Shared state encoding and lamp patterns for the Thunderbird tail-light sequencer.
// Latency: n/a (constants only); backpressure: none.
package tbird_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_L1    = 4'd1,
        S_L2    = 4'd2,
        S_L3    = 4'd3,
        S_R1    = 4'd4,
        S_R2    = 4'd5,
        S_R3    = 4'd6,
        S_H_ON  = 4'd7,
        S_H_OFF = 4'd8
    } state_t;

    // Bit order: [5]=LC [4]=LB [3]=LA [2]=RA [1]=RB [0]=RC
    localparam logic [5:0] PAT_IDLE = 6'b000000;
    localparam logic [5:0] PAT_L1   = 6'b001000;
    localparam logic [5:0] PAT_L2   = 6'b011000;
    localparam logic [5:0] PAT_L3   = 6'b111000;
    localparam logic [5:0] PAT_R1   = 6'b000100;
    localparam logic [5:0] PAT_R2   = 6'b000110;
    localparam logic [5:0] PAT_R3   = 6'b000111;
    localparam logic [5:0] PAT_ALL  = 6'b111111;

    function automatic logic [5:0] state_pattern(input state_t s);
        case (s)
            S_L1:    return PAT_L1;
            S_L2:    return PAT_L2;
            S_L3:    return PAT_L3;
            S_R1:    return PAT_R1;
            S_R2:    return PAT_R2;
            S_R3:    return PAT_R3;
            S_H_ON:  return PAT_ALL;
            default: return PAT_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/tbird_sequencer_if.sv
// Request switches in, lamp pattern / dim clock / busy out.
// Latency: n/a (wiring only); backpressure: none.
interface tbird_sequencer_if;
    logic       left;
    logic       right;
    logic       hazard;
    logic [5:0] lights;
    logic       dim_clk;
    logic       busy;

    modport master (output left, right, hazard, input lights, dim_clk, busy);
    modport slave  (input left, right, hazard, output lights, dim_clk, busy);
endinterface

// File: rtl/tbird_sequencer_clk_divider.sv
// Free-running divide-by-DIV counter; out is the wrap pulse, or a wrap-toggled square wave when TOGGLE=1.
// Latency: first wrap at cycle DIV-1 after reset; backpressure: none.
module clk_divider #(
    parameter int DIV    = 2,
    parameter bit TOGGLE = 1'b0
) (
    input  logic clock,
    input  logic resetn,
    output logic out
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;
    logic          tgl;

    assign wrap = (cnt == CW'(DIV - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
            tgl <= 1'b0;
        end else if (wrap) begin
            cnt <= '0;
            tgl <= ~tgl;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign out = TOGGLE ? tgl : wrap;

endmodule

// File: rtl/tbird_sequencer.sv
// Thunderbird tail-light sequencer: turn/hazard FSM stepping once per TICK_DIV cycles, plus dim clock.
// Latency: request visible after 2-flop sync, acted on at next tick; backpressure: none.
module tbird_sequencer
    import tbird_pkg::*;
#(
    parameter int TICK_DIV = 25000000,
    parameter int DIM_DIV  = 4
) (
    input  logic                clock,
    input  logic                resetn,
    tbird_sequencer_if.slave    bus
);
    logic [2:0] sync1, sync2;
    logic       left_s, right_s, hazard_s, haz;
    logic       tick;
    state_t     state_q, state_d;

    // Switches are asynchronous; the slow tick hides any bounce after sync.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {bus.left, bus.right, bus.hazard};
            sync2 <= sync1;
        end
    end

    assign {left_s, right_s, hazard_s} = sync2;
    assign haz = hazard_s | (left_s & right_s);

    clk_divider #(.DIV(TICK_DIV), .TOGGLE(1'b0)) u_tick (
        .clock  (clock),
        .resetn (resetn),
        .out    (tick)
    );

    clk_divider #(.DIV(DIM_DIV), .TOGGLE(1'b1)) u_dim (
        .clock  (clock),
        .resetn (resetn),
        .out    (bus.dim_clk)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (haz)          state_d = S_H_ON;
                    else if (left_s)  state_d = S_L1;
                    else if (right_s) state_d = S_R1;
                    else              state_d = S_IDLE;
                end
                S_L1:    state_d = haz ? S_H_ON : S_L2;
                S_L2:    state_d = haz ? S_H_ON : S_L3;
                S_L3:    state_d = haz ? S_H_ON : S_IDLE;
                S_R1:    state_d = haz ? S_H_ON : S_R2;
                S_R2:    state_d = haz ? S_H_ON : S_R3;
                S_R3:    state_d = haz ? S_H_ON : S_IDLE;
                S_H_ON:  state_d = S_H_OFF;
                S_H_OFF: state_d = haz ? S_H_ON : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.lights = state_pattern(state_q);
    assign bus.busy   = (state_q != S_IDLE);

endmodule

// File: doc/tbird_sequencer.md
Name: tbird_sequencer

Overview:
- Generates the 6-bit tail-light pattern for the lab 5 Thunderbird light controller: left/right turn sequences and hazard flashing.
- Its `lights` output feeds the downstream lamp-dimming stage's `in` port.
- Its `dim_clk` output is the blink/duty clock for that stage.
- Contains one prescaled state machine advancing on a slow tick, plus a free-running dim-clock divider.

Parameters:
TICK_DIV, 25000000, clock cycles per sequence step (500 ms at 50 MHz); legal range 2 or more
DIM_DIV, 4, clock cycles per half-period of dim_clk; legal range 1 or more

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
left  input  1  left turn request, asynchronous (switch)
right  input  1  right turn request, asynchronous (switch)
hazard  input  1  hazard request, asynchronous (switch)
lights  output  6  lamp pattern; [5]=LC [4]=LB [3]=LA [2]=RA [1]=RB [0]=RC, 1=lamp on
dim_clk  output  1  square wave for the dimming stage; period 2*DIM_DIV cycles
busy  output  1  1 when the state is not IDLE

Behaviour:
- Interface (already decided): a single clock `clock`; reset `resetn` is asynchronous and active-low.
- Reset (resetn=0, asynchronous) forces:
  - state=IDLE, lights=6'b000000, busy=0, dim_clk=0;
  - tick counter=0, dim counter=0;
  - synchronizer flops=0.
- Input sync:
  - left, right and hazard each pass through a 2-flop synchronizer.
  - The FSM sees the synced values (2-cycle latency).
  - No debounce is done; the slow tick masks bounce.
- Tick:
  - The counter counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for exactly one cycle when count==TICK_DIV-1.
  - The first tick after reset occurs at cycle TICK_DIV-1.
- dim_clk:
  - The dim counter counts 0..DIM_DIV-1.
  - dim_clk toggles on the wrap.
  - It runs continuously, independent of the FSM.
- FSM states are IDLE, L1, L2, L3, R1, R2, R3, H_ON, H_OFF. The state changes only on the cycle where tick=1; otherwise it holds.
- Transitions on tick (syncs sampled that cycle):
  - IDLE:
    - hazard=1, or left=1 and right=1 -> H_ON;
    - else left -> L1;
    - else right -> R1;
    - else IDLE.
  - L1->L2->L3->IDLE and R1->R2->R3->IDLE. A started sequence runs to completion even if its request drops.
  - Hazard preemption: in any of L1..R3, if hazard=1, or left=1 and right=1, go to H_ON instead of the normal next state.
  - H_ON -> H_OFF unconditionally.
  - H_OFF:
    - hazard=1, or left=1 and right=1 -> H_ON;
    - else IDLE.
    - After IDLE, a still-held single turn request starts its sequence on the next tick.
- Moore decode, combinational from the state register only (no input paths):
  - IDLE = 000000, L1 = 001000, L2 = 011000, L3 = 111000;
  - R1 = 000100, R2 = 000110, R3 = 000111;
  - H_ON = 111111, H_OFF = 000000.
- busy = (state != IDLE).
- Simultaneous events: the tick and a request change in the same cycle use the already-synced value. An input edge therefore needs 2 cycles plus the wait to the next tick to take effect.
- Reset mid-sequence: lights go to 0 immediately and asynchronously, and the tick phase restarts from 0.

Decomposition:
- Shared package tbird_pkg holds:
  - the state encoding constants (4-bit, binary);
  - the lamp-pattern constants (PAT_IDLE, PAT_L1..PAT_L3, PAT_R1..PAT_R3, PAT_ALL).
- Sub-module clk_divider(DIV) is natural: counter plus wrap pulse, with optional toggle output.
  - Instance 1 generates tick.
  - Instance 2 generates dim_clk.

Test Plan:
- Use TICK_DIV=4 and DIM_DIV=2 for all scenarios.
1. Reset, all inputs 0 -> lights=000000, busy=0, dim_clk toggles every 2 cycles (period 4); lights still 000000 after 40 cycles.
2. left=1 held -> successive ticks show 001000, 011000, 111000, 000000, 001000; each pattern lasts exactly 4 cycles; busy=0 only during the IDLE step.
3. right pulsed high for 6 cycles then 0 -> 000100, 000110, 000111, then 000000 held, i.e. the sequence completes after release.
4. left=1, then hazard=1 asserted while in L2 -> next tick lights=111111, then alternating 000000/111111 each tick while hazard is held; hazard=0 during H_ON -> H_OFF, then IDLE.
5. left=1 and right=1 together from IDLE -> 111111/000000 flashing, identical to hazard.
6. resetn pulled low for 1 ns mid-R3 -> lights=000000 and busy=0 immediately without a clock edge; after release the first step occurs at cycle 3 post-reset.
